// File: rtl/bft_leaf_port_pkg.sv
// Shared constants and types for the BFT leaf port and its FIFOs.
package bft_leaf_port_pkg;

    // Width of the saturating bounce counter.
    localparam int BOUNCE_CNT_W = 16;

    // Outcome of one cycle's look at the switch leaf output.
    typedef enum logic [1:0] {
        ARR_NONE    = 2'd0,
        ARR_DELIVER = 2'd1,
        ARR_BOUNCE  = 2'd2
    } arrival_e;

    // Packet field positions for the layout {valid, dest_addr, payload}.
    function automatic int unsigned pkt_valid_idx(input int unsigned a_sz,
                                                  input int unsigned payload_sz);
        return a_sz + payload_sz;
    endfunction

    function automatic int unsigned pkt_addr_lsb(input int unsigned payload_sz);
        return payload_sz;
    endfunction

endpackage

// File: rtl/bft_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered occupancy count.
// depth must be a power of two so the pointers wrap naturally.
module bft_sync_fifo
    import bft_leaf_port_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);

    localparam int PW = $clog2(depth);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(depth);

    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/bft_leaf_port.sv
// Leaf-side network interface for the bufferless deflection BFT.
// Buffers PE injections, delivers arrivals for this leaf, and re-injects
// misrouted or unacceptable arrivals ahead of any new injection.
module bft_leaf_port
    import bft_leaf_port_pkg::*;
#(
    parameter int num_leaves = 2,
    parameter int payload_sz = 1,
    parameter int addr       = 0,
    parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    input  logic [$clog2(num_leaves)-1:0] tx_addr,
    input  logic [payload_sz-1:0]         tx_payload,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [payload_sz-1:0]         rx_payload,
    input  logic [p_sz-1:0]               bus_i,
    output logic [p_sz-1:0]               bus_o,
    output logic [BOUNCE_CNT_W-1:0]       bounce_cnt
);

    localparam int a_sz  = $clog2(num_leaves);
    localparam int CW    = $clog2(fifo_depth) + 1;
    localparam int TXW   = a_sz + payload_sz;
    localparam int V_IDX = int'(pkt_valid_idx(a_sz, payload_sz));
    localparam int A_LSB = int'(pkt_addr_lsb(payload_sz));

    localparam logic [a_sz-1:0] MY_ADDR = a_sz'(addr);
    localparam logic [CW-1:0]   DEPTH_C = CW'(fifo_depth);

    logic [TXW-1:0]          tx_head;
    logic                    tx_full;
    logic                    tx_empty;
    logic [CW-1:0]           tx_count;
    logic                    tx_pop;
    logic                    rx_full;
    logic                    rx_empty;
    logic [CW-1:0]           rx_count;
    logic                    rx_push;

    logic                    in_valid;
    logic [a_sz-1:0]         in_dest;
    logic [payload_sz-1:0]   in_payload;
    arrival_e                arr;

    logic [p_sz-1:0]         bus_q;
    logic [p_sz-1:0]         bus_d;
    logic [BOUNCE_CNT_W-1:0] bcnt_q;
    logic [BOUNCE_CNT_W-1:0] bcnt_d;

    assign in_valid   = bus_i[V_IDX];
    assign in_dest    = bus_i[A_LSB +: a_sz];
    assign in_payload = bus_i[payload_sz-1:0];

    assign tx_ready   = (tx_count != DEPTH_C);
    assign rx_valid   = !rx_empty;
    assign rx_push    = (arr == ARR_DELIVER);
    assign tx_pop     = (arr != ARR_BOUNCE) && !tx_empty;
    assign bus_o      = bus_q;
    assign bounce_cnt = bcnt_q;

    bft_sync_fifo #(
        .width (TXW),
        .depth (fifo_depth)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid && tx_ready),
        .pop   (tx_pop),
        .din   ({tx_addr, tx_payload}),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    bft_sync_fifo #(
        .width (payload_sz),
        .depth (fifo_depth)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_ready),
        .din   (in_payload),
        .dout  (rx_payload),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // Classify the arrival; a same-cycle RX pop never makes room for it.
    always_comb begin
        arr = ARR_NONE;
        if (in_valid) begin
            if ((in_dest == MY_ADDR) && (rx_count < DEPTH_C)) begin
                arr = ARR_DELIVER;
            end else begin
                arr = ARR_BOUNCE;
            end
        end
    end

    // Next bus word: bounce first, then TX head, else idle; bounce counter saturates.
    always_comb begin
        bus_d  = '0;
        bcnt_d = bcnt_q;
        if (arr == ARR_BOUNCE) begin
            bus_d = bus_i;
            if (bcnt_q != '1) begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else if (!tx_empty) begin
            bus_d = p_sz'({1'b1, tx_head});
        end
    end

    // Output register and bounce counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus_q  <= '0;
            bcnt_q <= '0;
        end else begin
            bus_q  <= bus_d;
            bcnt_q <= bcnt_d;
        end
    end

    // The FIFO full flags must agree with the counts used for flow control.
    a_full_consistent: assert property (@(posedge clk) disable iff (!reset)
        (tx_full == (tx_count == DEPTH_C)) && (rx_full == (rx_count == DEPTH_C)));

endmodule

// File: tb/tb_bft_leaf_port.sv
// Scoreboard bench for bft_leaf_port: a queue-based reference model predicts
// every bus_o word and every RX payload; a negedge monitor compares.
module tb_bft_leaf_port;

    localparam int NL   = 8;
    localparam int PL   = 8;
    localparam int ADDR = 3;
    localparam int PS   = 12;
    localparam int DEP  = 4;

    logic          clk;
    logic          reset;
    logic          tx_valid;
    logic          tx_ready;
    logic [2:0]    tx_addr;
    logic [7:0]    tx_payload;
    logic          rx_valid;
    logic          rx_ready;
    logic [7:0]    rx_payload;
    logic [11:0]   bus_i;
    logic [11:0]   bus_o;
    logic [15:0]   bounce_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [10:0]   m_tx[$];
    logic [11:0]   exp_bus[$];
    logic [7:0]    exp_rx[$];
    int            m_rx_occ = 0;
    logic [15:0]   m_bcnt = '0;

    bft_leaf_port #(
        .num_leaves (NL),
        .payload_sz (PL),
        .addr       (ADDR),
        .p_sz       (PS),
        .fifo_depth (DEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_addr    (tx_addr),
        .tx_payload (tx_payload),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_payload (rx_payload),
        .bus_i      (bus_i),
        .bus_o      (bus_o),
        .bounce_cnt (bounce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply the leaf-port rules to the inputs seen at each edge.
    always @(posedge clk) begin
        logic [11:0] e;
        logic        bounce;
        logic        deliver;
        logic        tx_acc;
        e = '0;
        if (!reset) begin
            m_tx.delete();
            exp_rx.delete();
            m_rx_occ = 0;
            m_bcnt   = '0;
        end else begin
            tx_acc  = tx_valid && (m_tx.size() < DEP);
            bounce  = bus_i[11] && ((bus_i[10:8] != 3'(ADDR)) || (m_rx_occ == DEP));
            deliver = bus_i[11] && !bounce;
            if (bounce) begin
                e = bus_i;
                if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
            end else if (m_tx.size() > 0) begin
                e = {1'b1, m_tx.pop_front()};
            end
            if (rx_ready && (m_rx_occ > 0)) m_rx_occ = m_rx_occ - 1;
            if (deliver) begin
                m_rx_occ = m_rx_occ + 1;
                exp_rx.push_back(bus_i[7:0]);
            end
            if (tx_acc) m_tx.push_back({tx_addr, tx_payload});
        end
        exp_bus.push_back(e);
    end

    // Monitor: compare DUT outputs against the scoreboard away from the edge.
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            chk("bus_o", 32'(bus_o), 32'(e));
            chk("tx_ready", 32'(tx_ready), 32'(m_tx.size() != DEP));
            chk("rx_valid", 32'(rx_valid), 32'(m_rx_occ != 0));
            chk("bounce_cnt", 32'(bounce_cnt), 32'(m_bcnt));
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_pop: got %0h expected nothing", rx_payload);
                end else begin
                    chk("rx_payload", 32'(rx_payload), 32'(exp_rx.pop_front()));
                end
            end
        end
    end

    task automatic cycle(input logic rst, input logic tv, input logic [2:0] ta,
                         input logic [7:0] tp, input logic rr, input logic [11:0] bi);
        reset      = rst;
        tx_valid   = tv;
        tx_addr    = ta;
        tx_payload = tp;
        rx_ready   = rr;
        bus_i      = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        cycle(1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
    endtask

    initial begin
        logic [11:0] w;
        logic [2:0]  d;
        cycle(1'b0, 1'b1, 3'd5, 8'hA5, 1'b0, 12'hB3C);

        // Reset with a valid arrival and a TX offer present
        cycle(1'b0, 1'b1, 3'd5, 8'hA5, 1'b1, 12'hB3C);
        chk("rst_bus_o", 32'(bus_o), 32'h0);
        chk("rst_bcnt", 32'(bounce_cnt), 32'h0);
        chk("rst_tx_ready", 32'(tx_ready), 32'h1);
        chk("rst_rx_valid", 32'(rx_valid), 32'h0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        chk("idle_bus_o", 32'(bus_o), 32'h0);

        // Injection: dest 5 payload A5
        cycle(1'b1, 1'b1, 3'd5, 8'hA5, 1'b0, 12'd0);
        chk("inj_lat0", 32'(bus_o), 32'h0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        chk("inj_bus_o", 32'(bus_o), 32'hDA5);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        chk("inj_after", 32'(bus_o), 32'h0);

        // Delivery to this leaf
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'hB3C);
        chk("dlv_rx_valid", 32'(rx_valid), 32'h1);
        chk("dlv_rx_payload", 32'(rx_payload), 32'h3C);
        chk("dlv_bus_o", 32'(bus_o), 32'h0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 12'd0);
        chk("dlv_popped", 32'(rx_valid), 32'h0);

        // Misroute while TX holds a packet
        do_reset();
        cycle(1'b1, 1'b1, 3'd1, 8'h77, 1'b0, 12'd0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'hE11);
        chk("mis_bus_o", 32'(bus_o), 32'hE11);
        chk("mis_bcnt", 32'(bounce_cnt), 32'h1);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        chk("mis_tx_out", 32'(bus_o), 32'h977);

        // RX full: four held, fifth bounced even with a same-cycle pop
        for (int unsigned p = 0; p < 4; p++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'hB40 + 12'(p));
        end
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 12'hB55);
        chk("rxf_bounce", 32'(bus_o), 32'hB55);
        chk("rxf_bcnt", 32'(bounce_cnt), 32'h2);
        for (int unsigned p = 0; p < 4; p++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 12'd0);
        end
        chk("rxf_drained", 32'(rx_valid), 32'h0);

        // TX full under continuous bounces, then ordered drain with wrap
        do_reset();
        for (int unsigned k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b1, 3'(k), 8'h60 + 8'(k), 1'b0, 12'h800);
        end
        chk("txf_not_ready", 32'(tx_ready), 32'h0);
        cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        chk("txf_ready_again", 32'(tx_ready), 32'h1);
        for (int unsigned k = 4; k < 10; k++) begin
            w = ($urandom_range(0, 1) == 0) ? 12'h800 | 12'(k) : 12'd0;
            cycle(1'b1, 1'b1, 3'(k), 8'h60 + 8'(k), 1'b0, w);
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        end
        for (int unsigned k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 12'd0);
        end

        // Randomized traffic with occasional mid-run resets
        for (int unsigned i = 0; i < 3000; i++) begin
            d = ($urandom_range(0, 1) == 0) ? 3'(ADDR) : 3'($urandom_range(0, 7));
            w = {1'b1, d, 8'($urandom)};
            if ($urandom_range(0, 2) != 0) w = {1'b0, 11'($urandom)};
            cycle(($urandom_range(0, 299) != 0),
                  1'($urandom),
                  3'($urandom),
                  8'($urandom),
                  (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  w);
        end

        // Drain
        for (int unsigned k = 0; k < 12; k++) begin
            cycle(1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 12'd0);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
